// File: rtl/fb_read_arbiter.sv
// Two-port AXI3 read-channel arbiter for the framebuffer read master.
// Port 0 is the primary scanout surface, port 1 the overlay/cursor plane. AR requests are
// serialised round-robin (or port 0 fixed priority), tagged with the port index in ARID[5],
// and R beats are routed back combinationally by RID[5]. Outstanding bursts are capped per port.
module fb_read_arbiter #(
    parameter int unsigned MAX_OUT    = 4,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        s0_arvalid_i,
    output logic        s0_arready_o,
    input  logic [5:0]  s0_arid_i,
    input  logic [31:0] s0_araddr_i,
    input  logic [3:0]  s0_arlen_i,
    output logic        s0_rvalid_o,
    input  logic        s0_rready_i,
    output logic [63:0] s0_rdata_o,
    output logic [5:0]  s0_rid_o,
    output logic [1:0]  s0_rresp_o,
    output logic        s0_rlast_o,

    input  logic        s1_arvalid_i,
    output logic        s1_arready_o,
    input  logic [5:0]  s1_arid_i,
    input  logic [31:0] s1_araddr_i,
    input  logic [3:0]  s1_arlen_i,
    output logic        s1_rvalid_o,
    input  logic        s1_rready_i,
    output logic [63:0] s1_rdata_o,
    output logic [5:0]  s1_rid_o,
    output logic [1:0]  s1_rresp_o,
    output logic        s1_rlast_o,

    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [5:0]  m_arid_o,
    output logic [31:0] m_araddr_o,
    output logic [3:0]  m_arlen_o,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [63:0] m_rdata_i,
    input  logic [5:0]  m_rid_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rlast_i
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUT);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e      state_q, state_d;
    logic        m_arvalid_q, m_arvalid_d;
    logic [5:0]  m_arid_q, m_arid_d;
    logic [31:0] m_araddr_q, m_araddr_d;
    logic [3:0]  m_arlen_q, m_arlen_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  out_cnt_q [2];
    logic [3:0]  out_cnt_d [2];

    logic [1:0]  elig;
    logic        sel;
    logic        ar_hs;
    logic        r_done;

    // Requester ID bit 5 is overwritten by the port tag.
    logic        unused_arid_bits;
    assign unused_arid_bits = s0_arid_i[5] ^ s1_arid_i[5];

    // Eligibility and grant selection; depends only on state, counts, last_grant and arvalid.
    always_comb begin
        elig[0] = s0_arvalid_i && (out_cnt_q[0] < MaxOut);
        elig[1] = s1_arvalid_i && (out_cnt_q[1] < MaxOut);
        if (elig[0] && elig[1]) begin
            sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            sel = elig[1];
        end
        // The selected port is always eligible, hence valid: ready implies handshake.
        ar_hs        = aresetn && (state_q == StIdle) && (elig != 2'b00);
        s0_arready_o = ar_hs && !sel;
        s1_arready_o = ar_hs && sel;
    end

    // AR FSM next state: capture the granted request, hold it until the master accepts.
    always_comb begin
        state_d      = state_q;
        m_arvalid_d  = m_arvalid_q;
        m_arid_d     = m_arid_q;
        m_araddr_d   = m_araddr_q;
        m_arlen_d    = m_arlen_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d      = StIssue;
                    m_arvalid_d  = 1'b1;
                    last_grant_d = sel;
                    if (sel) begin
                        m_arid_d   = {1'b1, s1_arid_i[4:0]};
                        m_araddr_d = s1_araddr_i;
                        m_arlen_d  = s1_arlen_i;
                    end else begin
                        m_arid_d   = {1'b0, s0_arid_i[4:0]};
                        m_araddr_d = s0_araddr_i;
                        m_arlen_d  = s0_arlen_i;
                    end
                end
            end
            StIssue: begin
                if (m_arready_i) begin
                    state_d     = StIdle;
                    m_arvalid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding-burst counters: +1 on grant, -1 on last beat accepted, saturating at 0.
    always_comb begin
        r_done = m_rvalid_i && m_rready_o && m_rlast_i;
        for (int i = 0; i < 2; i++) begin
            logic inc;
            logic dec;
            inc = ar_hs && (sel == 1'(i));
            dec = r_done && (m_rid_i[5] == 1'(i)) && (out_cnt_q[i] != 4'd0);
            out_cnt_d[i] = out_cnt_q[i] + 4'(inc) - 4'(dec);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            m_arvalid_q  <= 1'b0;
            m_arid_q     <= 6'd0;
            m_araddr_q   <= 32'd0;
            m_arlen_q    <= 4'd0;
            last_grant_q <= 1'b1;
            out_cnt_q[0] <= 4'd0;
            out_cnt_q[1] <= 4'd0;
        end else begin
            state_q      <= state_d;
            m_arvalid_q  <= m_arvalid_d;
            m_arid_q     <= m_arid_d;
            m_araddr_q   <= m_araddr_d;
            m_arlen_q    <= m_arlen_d;
            last_grant_q <= last_grant_d;
            out_cnt_q[0] <= out_cnt_d[0];
            out_cnt_q[1] <= out_cnt_d[1];
        end
    end

    // R channel routing by RID[5]; data, response and last are broadcast.
    always_comb begin
        m_arvalid_o = m_arvalid_q;
        m_arid_o    = m_arid_q;
        m_araddr_o  = m_araddr_q;
        m_arlen_o   = m_arlen_q;
        s0_rvalid_o = m_rvalid_i && !m_rid_i[5];
        s1_rvalid_o = m_rvalid_i && m_rid_i[5];
        m_rready_o  = m_rid_i[5] ? s1_rready_i : s0_rready_i;
        s0_rdata_o  = m_rdata_i;
        s1_rdata_o  = m_rdata_i;
        s0_rid_o    = {1'b0, m_rid_i[4:0]};
        s1_rid_o    = {1'b0, m_rid_i[4:0]};
        s0_rresp_o  = m_rresp_i;
        s1_rresp_o  = m_rresp_i;
        s0_rlast_o  = m_rlast_i;
        s1_rlast_o  = m_rlast_i;
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter: reset, round-robin and fixed priority, outstanding limit,
// R routing, simultaneous count update, stray rlast and master stall with mid-stall reset.
module tb_fb_read_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [5:0]  s0_arid, s0_rid;
    logic [31:0] s0_araddr;
    logic [3:0]  s0_arlen;
    logic [63:0] s0_rdata;
    logic [1:0]  s0_rresp;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [5:0]  s1_arid, s1_rid;
    logic [31:0] s1_araddr;
    logic [3:0]  s1_arlen;
    logic [63:0] s1_rdata;
    logic [1:0]  s1_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [5:0]  m_arid, m_rid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;

    // Outputs of the fixed-priority instance (shares all inputs with the main DUT).
    logic        f0_arready, f0_rvalid, f0_rlast, f1_arready, f1_rvalid, f1_rlast;
    logic [5:0]  f0_rid, f1_rid, f_arid;
    logic [63:0] f0_rdata, f1_rdata;
    logic [1:0]  f0_rresp, f1_rresp;
    logic        f_arvalid, f_rready;
    logic [31:0] f_araddr;
    logic [3:0]  f_arlen;

    int n_tests = 0;
    int n_fail  = 0;

    fb_read_arbiter #(.MAX_OUT(4), .FIXED_PRIO(1'b0)) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_arid_i(s0_arid),
        .s0_araddr_i(s0_araddr), .s0_arlen_i(s0_arlen), .s0_rvalid_o(s0_rvalid),
        .s0_rready_i(s0_rready), .s0_rdata_o(s0_rdata), .s0_rid_o(s0_rid),
        .s0_rresp_o(s0_rresp), .s0_rlast_o(s0_rlast),
        .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_arid_i(s1_arid),
        .s1_araddr_i(s1_araddr), .s1_arlen_i(s1_arlen), .s1_rvalid_o(s1_rvalid),
        .s1_rready_i(s1_rready), .s1_rdata_o(s1_rdata), .s1_rid_o(s1_rid),
        .s1_rresp_o(s1_rresp), .s1_rlast_o(s1_rlast),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_arid_o(m_arid),
        .m_araddr_o(m_araddr), .m_arlen_o(m_arlen), .m_rvalid_i(m_rvalid),
        .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rid_i(m_rid),
        .m_rresp_i(m_rresp), .m_rlast_i(m_rlast)
    );

    fb_read_arbiter #(.MAX_OUT(4), .FIXED_PRIO(1'b1)) u_fix (
        .aclk(aclk), .aresetn(aresetn),
        .s0_arvalid_i(s0_arvalid), .s0_arready_o(f0_arready), .s0_arid_i(s0_arid),
        .s0_araddr_i(s0_araddr), .s0_arlen_i(s0_arlen), .s0_rvalid_o(f0_rvalid),
        .s0_rready_i(s0_rready), .s0_rdata_o(f0_rdata), .s0_rid_o(f0_rid),
        .s0_rresp_o(f0_rresp), .s0_rlast_o(f0_rlast),
        .s1_arvalid_i(s1_arvalid), .s1_arready_o(f1_arready), .s1_arid_i(s1_arid),
        .s1_araddr_i(s1_araddr), .s1_arlen_i(s1_arlen), .s1_rvalid_o(f1_rvalid),
        .s1_rready_i(s1_rready), .s1_rdata_o(f1_rdata), .s1_rid_o(f1_rid),
        .s1_rresp_o(f1_rresp), .s1_rlast_o(f1_rlast),
        .m_arvalid_o(f_arvalid), .m_arready_i(m_arready), .m_arid_o(f_arid),
        .m_araddr_o(f_araddr), .m_arlen_o(f_arlen), .m_rvalid_i(m_rvalid),
        .m_rready_o(f_rready), .m_rdata_i(m_rdata), .m_rid_i(m_rid),
        .m_rresp_i(m_rresp), .m_rlast_i(m_rlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn    = 1'b0;
        s0_arvalid = 1'b1; s0_arid = 6'h25; s0_araddr = 32'h1000_0000; s0_arlen = 4'd3;
        s1_arvalid = 1'b1; s1_arid = 6'h0a; s1_araddr = 32'h2000_0040; s1_arlen = 4'd1;
        s0_rready  = 1'b0; s1_rready = 1'b0;
        m_arready  = 1'b1; m_rvalid = 1'b0; m_rid = 6'h00; m_rlast = 1'b0;
        m_rdata    = 64'd0; m_rresp = 2'b00;

        // Reset held 3 cycles with both requesters asking.
        repeat (3) begin
            tick();
            chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
            chk("rst_s0_arready", 64'(s0_arready), 64'd0);
            chk("rst_s1_arready", 64'(s1_arready), 64'd0);
        end
        chk("rst_m_araddr", 64'(m_araddr), 64'd0);
        aresetn = 1'b1;
        #1;
        chk("rel_s0_arready", 64'(s0_arready), 64'd1);
        chk("rel_s1_arready", 64'(s1_arready), 64'd0);

        // Round-robin 0,1,0,1,0 one AR per 2 cycles; fixed priority 0,0,0,0 then 1 (port 0 full).
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rr_m_arvalid", 64'(m_arvalid), 64'((i % 2) == 0));
            chk("fx_m_arvalid", 64'(f_arvalid), 64'((i % 2) == 0));
            if ((i % 2) == 0) begin
                chk("rr_m_arid", 64'(m_arid), (((i / 2) % 2) == 0) ? 64'h05 : 64'h2a);
                chk("rr_m_araddr", 64'(m_araddr),
                    (((i / 2) % 2) == 0) ? 64'h1000_0000 : 64'h2000_0040);
                chk("rr_issue_s0_arready", 64'(s0_arready), 64'd0);
                chk("fx_m_arid", 64'(f_arid), ((i / 2) < 4) ? 64'h05 : 64'h2a);
            end
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;

        // Drain: main counts are port0=3, port1=2.
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 6'h00; s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        chk("drain_s0_rvalid", 64'(s0_rvalid), 64'd1);
        chk("drain_s1_rvalid", 64'(s1_rvalid), 64'd0);
        repeat (3) tick();
        m_rid = 6'h20;
        repeat (2) tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // R routing with backpressure from port 1.
        m_rvalid = 1'b1; m_rid = 6'h23; m_rdata = 64'hdead_beef_0123_4567; m_rresp = 2'b10;
        s1_rready = 1'b0; s0_rready = 1'b1;
        #1;
        chk("route_s1_rvalid", 64'(s1_rvalid), 64'd1);
        chk("route_s0_rvalid", 64'(s0_rvalid), 64'd0);
        chk("route_s1_rid", 64'(s1_rid), 64'h03);
        chk("route_m_rready_lo", 64'(m_rready), 64'd0);
        chk("route_s0_rdata", s0_rdata, 64'hdead_beef_0123_4567);
        chk("route_s1_rresp", 64'(s1_rresp), 64'd2);
        tick();
        chk("route_m_rready_lo2", 64'(m_rready), 64'd0);
        tick();
        s1_rready = 1'b1;
        #1;
        chk("route_m_rready_hi", 64'(m_rready), 64'd1);
        m_rvalid = 1'b0;

        // Outstanding limit: port 0 issues 4 bursts, then is blocked while port 1 is still served.
        s0_arvalid = 1'b1;
        #1;
        chk("lim_s0_first", 64'(s0_arready), 64'd1);
        repeat (8) tick();
        chk("lim_s0_blocked", 64'(s0_arready), 64'd0);
        tick();
        chk("lim_s0_blocked2", 64'(s0_arready), 64'd0);
        chk("lim_m_arvalid", 64'(m_arvalid), 64'd0);
        s1_arvalid = 1'b1;
        #1;
        chk("lim_s1_granted", 64'(s1_arready), 64'd1);
        chk("lim_s0_still_blk", 64'(s0_arready), 64'd0);
        tick();
        chk("lim_s1_issue", 64'(m_arid), 64'h2a);
        s1_arvalid = 1'b0;
        tick();
        chk("lim_s0_blk_idle", 64'(s0_arready), 64'd0);
        m_rvalid = 1'b1; m_rid = 6'h00; m_rlast = 1'b1;
        #1;
        chk("lim_s0_blk_rbeat", 64'(s0_arready), 64'd0);
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("lim_s0_reopen", 64'(s0_arready), 64'd1);

        // Bring port 0 to 2, then AR handshake coincident with rlast: count stays 2.
        s0_arvalid = 1'b0; m_rvalid = 1'b1;
        tick();
        s0_arvalid = 1'b1;
        #1;
        chk("sim_s0_ready", 64'(s0_arready), 64'd1);
        tick();
        m_rvalid = 1'b0;
        tick();
        chk("sim_cnt2_open", 64'(s0_arready), 64'd1);
        repeat (2) tick();
        chk("sim_cnt3_open", 64'(s0_arready), 64'd1);
        repeat (2) tick();
        chk("sim_cnt4_full", 64'(s0_arready), 64'd0);
        s0_arvalid = 1'b0;

        // Port 1 at 1: one real rlast then a stray one at 0; it must remain eligible.
        m_rvalid = 1'b1; m_rid = 6'h20; m_rlast = 1'b1;
        repeat (2) tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;

        // Master stall with a 16-beat burst from port 1.
        s1_arvalid = 1'b1; s1_araddr = 32'h0010_0000; s1_arlen = 4'd15; m_arready = 1'b0;
        #1;
        chk("stray_s1_ready", 64'(s1_arready), 64'd1);
        tick();
        chk("stall_m_arid", 64'(m_arid), 64'h2a);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_m_arvalid", 64'(m_arvalid), 64'd1);
            chk("stall_m_araddr", 64'(m_araddr), 64'h0010_0000);
            chk("stall_m_arlen", 64'(m_arlen), 64'd15);
            chk("stall_s1_arready", 64'(s1_arready), 64'd0);
        end
        aresetn = 1'b0;
        tick();
        chk("stall_rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("stall_rst_araddr", 64'(m_araddr), 64'd0);
        aresetn = 1'b1; s1_arvalid = 1'b0; m_arready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Two-port AXI3 read-channel arbiter that shares the single 64-bit framebuffer read master between two scanout requesters: port 0 is the primary display surface and port 1 is an overlay or cursor plane. It sits between the requesters' AR/R channels and the memory interconnect. It serialises AR requests round-robin (or port 0 fixed priority), tags each burst with the requester index in the ID MSB, routes R beats back by ID, and limits outstanding bursts per port. AW/W/B channels are not handled.

## Interface
- MAX_OUT, 4: maximum outstanding read bursts per port, 1..15.
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 wins whenever it is eligible.

Ports (N = 0, 1):
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- sN_arvalid  in  1  requester address valid
- sN_arready  out  1  requester address ready
- sN_arid  in  6  requester ID; bit 5 ignored
- sN_araddr  in  32  burst start address
- sN_arlen  in  4  burst length minus one
- sN_rvalid  out  1  read data valid to requester
- sN_rready  in  1  requester read ready
- sN_rdata  out  64  read data (broadcast)
- sN_rid  out  6  returned ID, {1'b0, m_rid[4:0]}
- sN_rresp  out  2  read response (broadcast)
- sN_rlast  out  1  last beat (broadcast)
- m_arvalid  out  1  master address valid
- m_arready  in  1  master address ready
- m_arid  out  6  {N, sN_arid[4:0]}
- m_araddr  out  32  registered address
- m_arlen  out  4  registered length
- m_rvalid  in  1  master read valid
- m_rready  out  1  master read ready
- m_rdata  in  64  read data
- m_rid  in  6  read ID; bit 5 selects port
- m_rresp  in  2  read response
- m_rlast  in  1  last beat

## Operation
- **Reset:** all state resets while aresetn=0.
  - m_arvalid=0; m_arid, m_araddr, m_arlen=0.
  - out_cnt[0..1]=0; last_grant=1, so port 0 wins the first tie; state=IDLE.
  - sN_arready=0 while aresetn=0.
- **Eligibility:** port N is eligible when sN_arvalid=1 and out_cnt[N] < MAX_OUT.
- **IDLE state:**
  - Select one eligible port. Round-robin prefers the port that is not last_grant; if only one port is eligible, select it.
  - sN_arready is combinational and is 1 only for the selected port, only in IDLE.
  - On the sN handshake: capture m_arid={N, sN_arid[4:0]}, m_araddr, m_arlen; set m_arvalid=1; set last_grant=N; increment out_cnt[N]; go to ISSUE.
- **ISSUE state:**
  - Both sN_arready=0. m_ar* are held stable.
  - On m_arvalid & m_arready: m_arvalid=0; go to IDLE.
- **R routing (combinational, no storage):**
  - sN_rvalid = m_rvalid & (m_rid[5]==N).
  - m_rready = m_rid[5] ? s1_rready : s0_rready.
  - rdata, rresp and rlast go to both ports.
- **Counter decrement:** on m_rvalid & m_rready & m_rlast, out_cnt[m_rid[5]] decrements.
  - Increment and decrement of the same port in the same cycle leaves the count unchanged.
  - A decrement at count 0 is ignored; the count saturates at 0.
- **Counter width:** 4 bits, and it never exceeds MAX_OUT.
- **Reset mid-operation:** pending AR and outstanding counts are discarded. The interconnect is reset together with this block.

## Timing
- AR latency is 1 cycle from the slave handshake to m_arvalid=1, so at most one AR per 2 cycles.
- No combinational path from m_arready to sN_arready. sN_arready depends only on state, counts, last_grant and sN_arvalid.
- R path has zero latency; R backpressure passes straight through.
- A port blocked at MAX_OUT never stalls the other port's grant.
- With FIXED_PRIO=1, port 1 can starve. This is accepted by design.

## Test plan
- **Reset:** hold aresetn=0 for 3 cycles with both arvalid=1 → m_arvalid=0, s0/s1_arready=0, all counts 0. On the first cycle after release, s0_arready=1.
- **Round-robin:** both ports request continuously; m_arready=1; R returns rlast promptly → m_arid[5] sequence 0,1,0,1 and one AR every 2 cycles. With FIXED_PRIO=1 the sequence is 0,0,0,0.
- **Outstanding limit:** port 0 issues 4 bursts with no R returned → s0_arready stays 0 while s1 is still granted. After one m_rid=6'h00 rlast beat, port 0 is accepted again.
- **R routing:** m_rvalid=1, m_rid=6'h23, s1_rready=0 for 2 cycles, then 1 → s1_rvalid=1, s1_rid=6'h03, s0_rvalid=0, and m_rready tracks s1_rready.
- **Simultaneous update:** port 0 count=2; a port 0 AR handshake coincides with an m_rid[5]=0 rlast beat → count stays 2. A stray rlast at count 0 leaves the count at 0.
- **Master stall:** m_arready=0 for 10 cycles during ISSUE → m_arvalid, m_araddr=0x0010_0000 and m_arlen=15 are stable; no sN_arready. Asserting aresetn=0 mid-stall → m_arvalid=0 next cycle.
